pc_gen: RTL and testbench

Parametrised program-counter generator for the MIPS pipeline fetch stage. It holds the fetch PC and selects the next PC from five sources: exception redirect, jump, return, taken branch, or sequential increment. A small circular return-address stack (RAS) serves `jr $ra`-style returns without waiting on the register file. It replaces the fixed 32-bit PC and is driven by the hazard unit (`pc_write`) and the decode/execute control signals.

---
 rtl/pc_gen_if.sv | 38 +++
 rtl/pc_gen.sv | 138 +++++++++++++
 tb/tb_pc_gen.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-PC control/status bundle between the hazard/decode/execute logic and
// the PC generator.
//   master: drives pc_write, exc/exc_vector, jump/call/jump_address, ret,
//           branch/branch_taken/branch_address; observes pc_out and RAS flags
//   slave : the PC generator (pc_gen)
interface pc_gen_if #(
  parameter int unsigned PC_W = 32
) ();

  logic            pc_write;
  logic            exc;
  logic [PC_W-1:0] exc_vector;
  logic            jump;
  logic            call;
  logic [PC_W-1:0] jump_address;
  logic            ret;
  logic            branch;
  logic            branch_taken;
  logic [PC_W-1:0] branch_address;

  logic [PC_W-1:0] pc_out;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_underflow;

  modport master (
    output pc_write, exc, exc_vector, jump, call, jump_address,
           ret, branch, branch_taken, branch_address,
    input  pc_out, ras_empty, ras_full, ras_underflow
  );

  modport slave (
    input  pc_write, exc, exc_vector, jump, call, jump_address,
           ret, branch, branch_taken, branch_address,
    output pc_out, ras_empty, ras_full, ras_underflow
  );

endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with optional return-address stack.
// Next PC priority: exception > stall > jump > return > taken branch > PC+INC.
// Optional feature macro: PC_RAS_EN (defined = circular RAS for call/return;
// undefined = no RAS, ret always targets jump_address, flags held constant).
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous active-low reset
//   bus  - pc_gen_if.slave: control inputs, pc_out and RAS status outputs
// Parameters: PC_W, RESET_PC, INC (1 word / 4 byte addressing),
//   RAS_DEPTH (power of two, 2..16).
module pc_gen #(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned     INC       = 1,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  pc_gen_if.slave bus
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc_c;
  logic            underflow_q, underflow_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  // top_q points at the newest entry; count_q saturates at RAS_DEPTH
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_c;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
`else
  logic unused_call;
  assign unused_call = bus.call;
`endif

  assign pc_inc_c = pc_q + PC_W'(INC);

  // Next-PC selection and RAS bookkeeping
  always_comb begin
    pc_d        = pc_q;
    underflow_d = 1'b0;
    empty_d     = 1'b1;
    full_d      = 1'b0;
`ifdef PC_RAS_EN
    top_d       = top_q;
    count_d     = count_q;
    push_c      = 1'b0;
`endif

    if (bus.exc) begin
      pc_d = bus.exc_vector;
    end else if (!bus.pc_write) begin
      pc_d = pc_q;
    end else if (bus.jump) begin
      pc_d = bus.jump_address;
`ifdef PC_RAS_EN
      if (bus.call) begin
        // a push when full lands on the oldest slot, overwriting it
        push_c = 1'b1;
        top_d  = top_q + PTR_W'(1);
        if (count_q != CNT_FULL) begin
          count_d = count_q + CNT_W'(1);
        end
      end
`endif
    end else if (bus.ret) begin
`ifdef PC_RAS_EN
      if (count_q != '0) begin
        pc_d    = ras_q[top_q];
        top_d   = top_q - PTR_W'(1);
        count_d = count_q - CNT_W'(1);
      end else begin
        pc_d        = bus.jump_address;
        underflow_d = 1'b1;
      end
`else
      pc_d = bus.jump_address;
`endif
    end else if (bus.branch && bus.branch_taken) begin
      pc_d = bus.branch_address;
    end else begin
      pc_d = pc_inc_c;
    end

`ifdef PC_RAS_EN
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);
`endif
  end

  // PC and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      underflow_q <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      underflow_q <= underflow_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
    end
  end

`ifdef PC_RAS_EN
  // RAS pointer and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_q   <= '0;
      count_q <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
    end
  end

  // RAS storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push_c) begin
      ras_q[top_d] <= pc_inc_c;
    end
  end
`endif

  assign bus.pc_out        = pc_q;
  assign bus.ras_empty     = empty_q;
  assign bus.ras_full      = full_q;
  assign bus.ras_underflow = underflow_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen (PC_W=32, RESET_PC=0, INC=4, RAS_DEPTH=4).
// Fixed vector table, directed call/return and reset sequences, then random
// traffic compared against a queue-based model of the next-PC rules.
module tb_pc_gen;

  localparam int unsigned DEPTH = 4;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pc_gen_if #(.PC_W(32)) bus ();

  pc_gen #(
    .PC_W     (32),
    .RESET_PC (32'h0),
    .INC      (4),
    .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_uf;
  logic [31:0] m_ras[$];

  typedef struct {
    logic        pw, exc, jmp, call, ret, br, tk;
    logic [31:0] ev, ja, ba;
    logic [31:0] exp_pc;
    logic        exp_empty, exp_uf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic pw, logic exc, logic jmp, logic call, logic ret,
                              logic br, logic tk, logic [31:0] ev, logic [31:0] ja,
                              logic [31:0] ba, logic [31:0] exp_pc);
    vec_t v;
    v.pw = pw; v.exc = exc; v.jmp = jmp; v.call = call; v.ret = ret;
    v.br = br; v.tk = tk; v.ev = ev; v.ja = ja; v.ba = ba;
    v.exp_pc = exp_pc; v.exp_empty = 1'b1; v.exp_uf = 1'b0;
    return v;
  endfunction

  task automatic set_in(logic pw, logic exc, logic jmp, logic call, logic ret,
                        logic br, logic tk, logic [31:0] ev, logic [31:0] ja,
                        logic [31:0] ba);
    bus.pc_write = pw; bus.exc = exc; bus.exc_vector = ev;
    bus.jump = jmp; bus.call = call; bus.jump_address = ja;
    bus.ret = ret; bus.branch = br; bus.branch_taken = tk;
    bus.branch_address = ba;
  endtask

  task automatic idle();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Next-PC rules applied to the inputs sampled at this edge
  function automatic void model_step();
    logic [31:0] seq;
    seq  = m_pc + 32'd4;
    m_uf = 1'b0;
    if (bus.exc) begin
      m_pc = bus.exc_vector;
    end else if (!bus.pc_write) begin
      m_pc = m_pc;
    end else if (bus.jump) begin
      if (RAS_ON && bus.call) begin
        m_ras.push_back(seq);
        if (m_ras.size() > DEPTH) m_ras.delete(0);
      end
      m_pc = bus.jump_address;
    end else if (bus.ret) begin
      if (RAS_ON && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
      end else begin
        m_pc = bus.jump_address;
        m_uf = RAS_ON;
      end
    end else if (bus.branch && bus.branch_taken) begin
      m_pc = bus.branch_address;
    end else begin
      m_pc = seq;
    end
  endfunction

  task automatic check_model(string tag);
    chk({tag, ".pc"},    bus.pc_out,                 m_pc);
    chk({tag, ".empty"}, 32'(bus.ras_empty),         32'(m_ras.size() == 0));
    chk({tag, ".full"},  32'(bus.ras_full),          32'(m_ras.size() == DEPTH));
    chk({tag, ".uf"},    32'(bus.ras_underflow),     32'(m_uf));
  endtask

  task automatic step_model(string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    m_pc = 32'h0;
    m_uf = 1'b0;

    // Vector table: none of these involve a call or an unmatched return
    vecs.push_back(mk(1,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h4));
    vecs.push_back(mk(1,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h8));
    vecs.push_back(mk(1,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'hC));
    vecs.push_back(mk(1,0,1,0,0,0,0, 32'h0, 32'h100, 32'h0, 32'h100));
    vecs.push_back(mk(1,0,0,0,0,1,1, 32'h0, 32'h0, 32'h300, 32'h300));
    vecs.push_back(mk(1,0,0,0,0,1,0, 32'h0, 32'h0, 32'h900, 32'h304));
    vecs.push_back(mk(0,0,1,0,1,1,1, 32'h0, 32'h500, 32'h600, 32'h304));
    vecs.push_back(mk(0,1,0,0,0,0,0, 32'h80, 32'h0, 32'h0, 32'h80));
    vecs.push_back(mk(1,0,1,0,1,1,1, 32'h0, 32'h200, 32'h300, 32'h200));
    vecs.push_back(mk(1,0,0,0,0,1,0, 32'h0, 32'h0, 32'h300, 32'h204));
    vecs.push_back(mk(1,0,0,1,0,0,0, 32'h0, 32'h500, 32'h0, 32'h208));
    vecs.push_back(mk(1,0,1,0,0,0,0, 32'h0, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFC));
    vecs.push_back(mk(1,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(1,1,1,1,0,0,0, 32'h40, 32'h700, 32'h0, 32'h40));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset.pc",    bus.pc_out,                32'h0);
    chk("reset.empty", 32'(bus.ras_empty),        32'h1);
    chk("reset.full",  32'(bus.ras_full),         32'h0);
    chk("reset.uf",    32'(bus.ras_underflow),    32'h0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      set_in(vecs[i].pw, vecs[i].exc, vecs[i].jmp, vecs[i].call, vecs[i].ret,
             vecs[i].br, vecs[i].tk, vecs[i].ev, vecs[i].ja, vecs[i].ba);
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("vec%0d.pc", i),    bus.pc_out,            vecs[i].exp_pc);
      chk($sformatf("vec%0d.empty", i), 32'(bus.ras_empty),     32'(vecs[i].exp_empty));
      chk($sformatf("vec%0d.uf", i),    32'(bus.ras_underflow), 32'(vecs[i].exp_uf));
    end

    // Call to 0x400 from 0x100, two sequential fetches, then return
    set_in(1,0,1,0,0,0,0, 32'h0, 32'h100, 32'h0);  step_model("cr.j");
    set_in(1,0,1,1,0,0,0, 32'h0, 32'h400, 32'h0);  step_model("cr.call");
    idle();                                        step_model("cr.s1");
    step_model("cr.s2");
    set_in(1,0,0,0,1,0,0, 32'h0, 32'hDEAD0000, 32'h0); step_model("cr.ret");
    idle();                                        step_model("cr.after");

    // Five calls overflow a four-deep RAS, then five returns
    set_in(1,0,1,0,0,0,0, 32'h0, 32'h1000, 32'h0); step_model("ov.j");
    for (int i = 0; i < 5; i++) begin
      set_in(1,0,1,1,0,0,0, 32'h0, 32'h2000 + 32'(i) * 32'h100, 32'h0);
      step_model($sformatf("ov.call%0d", i));
    end
    for (int i = 0; i < 5; i++) begin
      set_in(1,0,0,0,1,0,0, 32'h0, 32'h7000, 32'h0);
      step_model($sformatf("ov.ret%0d", i));
    end
    idle();                                        step_model("ov.uf_clear");

    // Stall holds RAS, then an exception breaks through the stall
    set_in(1,0,1,1,0,0,0, 32'h0, 32'h3000, 32'h0); step_model("st.call");
    set_in(0,0,1,1,1,1,1, 32'h0, 32'h3100, 32'h3200); step_model("st.hold");
    set_in(0,1,0,0,1,0,0, 32'h80, 32'h0, 32'h0);   step_model("st.exc");
    idle();                                        step_model("st.run");

    // Asynchronous reset between edges, with the RAS non-empty
    set_in(1,0,1,1,0,0,0, 32'h0, 32'h5000, 32'h0); step_model("ar.call");
    idle();
    #2;
    rst = 1'b0;
    #1;
    chk("areset.pc",    bus.pc_out,             32'h0);
    chk("areset.empty", 32'(bus.ras_empty),     32'h1);
    chk("areset.full",  32'(bus.ras_full),      32'h0);
    m_pc = 32'h0;
    m_uf = 1'b0;
    m_ras.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step_model("ar.first");

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      set_in(($urandom % 8) != 0, ($urandom % 20) == 0, ($urandom % 4) == 0,
             ($urandom % 2) == 0, ($urandom % 3) == 0, ($urandom % 2) == 0,
             ($urandom % 2) == 0, $urandom & 32'hFFFFFFFC,
             $urandom & 32'hFFFFFFFC, $urandom & 32'hFFFFFFFC);
      step_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
